// File: rtl/seq_detect_pkg.sv
// Shared types and default sizes for the serial pattern detector slice.
package seq_detect_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_PAT_W  = 8;
  localparam int DEF_CNT_W  = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/seq_match_core.sv
// Moore-style serial matcher: bit history, fill count and a
// registered one-cycle match pulse.
module seq_match_core
  import seq_detect_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W,
  parameter int LEN_W = $clog2(PAT_W) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_valid,
  input  logic             bit_in,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  input  logic             overlap,
  input  logic             clr,
  output logic             det_pulse
);

  localparam logic [LEN_W-1:0] FULL = LEN_W'(PAT_W);
  localparam logic [LEN_W:0]   ONE  = (LEN_W+1)'(1);

  logic [PAT_W-1:0] hist;
  logic [PAT_W-1:0] hist_nxt;
  logic [PAT_W-1:0] mask;
  logic [LEN_W-1:0] fill;
  logic [LEN_W-1:0] fill_nxt;
  logic [LEN_W:0]   fill_inc;
  logic             match;

  always_comb begin
    hist_nxt = {hist[PAT_W-2:0], bit_in};
    for (int i = 0; i < PAT_W; i++) begin
      mask[i] = (i < int'(len));
    end
    fill_inc = {1'b0, fill} + ONE;
    match = (len != '0)
         && (fill_inc >= {1'b0, len})
         && (((hist_nxt ^ pattern) & mask) == '0);
    fill_nxt = fill;
    // Non-overlap restarts the count so the next hit needs len fresh bits
    if (match && !overlap) begin
      fill_nxt = '0;
    end else if (fill < FULL) begin
      fill_nxt = fill_inc[LEN_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      hist      <= '0;
      fill      <= '0;
      det_pulse <= 1'b0;
    end else begin
      det_pulse <= bit_valid && match;
      if (bit_valid) begin
        hist <= hist_nxt;
        fill <= fill_nxt;
      end
    end
  end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Word serialiser, config registers, match counter and threshold irq
// wrapped around the serial matcher.
module seq_detect_ctrl
  import seq_detect_pkg::*;
#(
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int PAT_W  = DEF_PAT_W,
  parameter  int CNT_W  = DEF_CNT_W,
  localparam int LEN_W  = $clog2(PAT_W) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              cfg_we,
  input  logic [PAT_W-1:0]  cfg_pattern,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic              cfg_overlap,
  input  logic [CNT_W-1:0]  cfg_thresh,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              det_pulse,
  output logic [CNT_W-1:0]  match_cnt,
  output logic              irq,
  input  logic              irq_clr,
  output logic              busy
);

  localparam int BC_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BC_W-1:0]  LAST = BC_W'(DATA_W - 1);
  localparam logic [BC_W-1:0]  BC1  = BC_W'(1);
  localparam logic [LEN_W-1:0] FULL = LEN_W'(PAT_W);
  localparam logic [CNT_W:0]   C1   = (CNT_W+1)'(1);

  state_t            state;
  state_t            state_nxt;
  logic [DATA_W-1:0] shreg;
  logic [BC_W-1:0]   bit_cnt;
  logic              last_bit;
  logic              hs;
  logic              cfg_wr;

  logic [PAT_W-1:0]  pat_r;
  logic [LEN_W-1:0]  len_r;
  logic              ovl_r;
  logic [CNT_W-1:0]  thr_r;
  logic [CNT_W:0]    cnt_inc;
  logic              irq_set;

  assign last_bit = (state == SHIFT) && (bit_cnt == LAST);
  assign hs       = s_valid && s_ready;
  assign cfg_wr   = cfg_we && (state == IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (hs) state_nxt = SHIFT;
      SHIFT: if (last_bit && !hs) state_nxt = IDLE;
    endcase
  end

  // Ready is forced low during reset so no word slips in mid-reset
  always_comb begin
    s_ready = enable && !rst && ((state == IDLE) || last_bit);
    busy    = (state == SHIFT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (hs) begin
      shreg   <= s_data;
      bit_cnt <= '0;
    end else if (state == SHIFT) begin
      shreg   <= {shreg[DATA_W-2:0], 1'b0};
      bit_cnt <= bit_cnt + BC1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pat_r <= '0;
      len_r <= '0;
      ovl_r <= 1'b1;
      thr_r <= '0;
    end else if (cfg_wr) begin
      pat_r <= cfg_pattern;
      len_r <= (cfg_len > FULL) ? FULL : cfg_len;
      ovl_r <= cfg_overlap;
      thr_r <= cfg_thresh;
    end
  end

  assign cnt_inc = {1'b0, match_cnt} + C1;
  assign irq_set = det_pulse && (thr_r != '0)
                && (cnt_inc == {1'b0, thr_r});

  always_ff @(posedge clk) begin
    if (rst || cfg_wr) begin
      match_cnt <= '0;
      irq       <= 1'b0;
    end else begin
      if (det_pulse && (match_cnt != '1)) begin
        match_cnt <= cnt_inc[CNT_W-1:0];
      end
      if (irq_set)      irq <= 1'b1;
      else if (irq_clr) irq <= 1'b0;
    end
  end

  seq_match_core #(
    .PAT_W (PAT_W),
    .LEN_W (LEN_W)
  ) u_core (
    .clk       (clk),
    .rst       (rst),
    .bit_valid (busy),
    .bit_in    (shreg[DATA_W-1]),
    .pattern   (pat_r),
    .len       (len_r),
    .overlap   (ovl_r),
    .clr       (cfg_wr),
    .det_pulse (det_pulse)
  );

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed bench for seq_detect_ctrl (16-bit and 4-bit counter builds).
module tb_seq_detect_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        cfg_we;
  logic [7:0]  cfg_pattern;
  logic [3:0]  cfg_len;
  logic        cfg_overlap;
  logic [15:0] cfg_thresh;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  s_data;
  logic        det_pulse;
  logic [15:0] match_cnt;
  logic        irq;
  logic        irq_clr;
  logic        busy;

  logic        s_ready_s;
  logic        det_pulse_s;
  logic [3:0]  match_cnt_s;
  logic        irq_s;
  logic        busy_s;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  seq_detect_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .cfg_we      (cfg_we),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .cfg_thresh  (cfg_thresh),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .det_pulse   (det_pulse),
    .match_cnt   (match_cnt),
    .irq         (irq),
    .irq_clr     (irq_clr),
    .busy        (busy)
  );

  seq_detect_ctrl #(.CNT_W(4)) dut_s (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .cfg_we      (cfg_we),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .cfg_thresh  (cfg_thresh[3:0]),
    .s_valid     (s_valid),
    .s_ready     (s_ready_s),
    .s_data      (s_data),
    .det_pulse   (det_pulse_s),
    .match_cnt   (match_cnt_s),
    .irq         (irq_s),
    .irq_clr     (irq_clr),
    .busy        (busy_s)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [7:0] p, input logic [3:0] l,
                     input logic o, input logic [15:0] t);
    cfg_pattern = p;
    cfg_len     = l;
    cfg_overlap = o;
    cfg_thresh  = t;
    cfg_we      = 1'b1;
    step();
    cfg_we      = 1'b0;
  endtask

  // pm[j-1] holds det_pulse as seen after bit j was sampled
  task automatic run_word(input logic [7:0] d, input int we_at,
                          input int en_at, output logic [7:0] pm);
    int w;
    pm = '0;
    w  = 0;
    while (!s_ready && w < 20) begin
      step();
      w++;
    end
    checks++;
    if (s_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_wait: s_ready=%b want 1", s_ready);
    end
    s_valid = 1'b1;
    s_data  = d;
    step();
    s_valid = 1'b0;
    for (int j = 1; j <= 8; j++) begin
      if (j == we_at) begin
        cfg_we  = 1'b1;
        cfg_len = 4'd0;
      end
      if (j == en_at) enable = 1'b0;
      step();
      cfg_we = 1'b0;
      pm[j-1] = det_pulse;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++;
    if (s_ready !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_hs: ready=%b busy=%b want 0 0", s_ready, busy);
    end
    checks++;
    if (det_pulse !== 1'b0 || match_cnt !== 16'd0 || irq !== 1'b0) begin
      errors++;
      $display("FAIL rst_out: det=%b cnt=%0d irq=%b want 0 0 0",
               det_pulse, match_cnt, irq);
    end
    rst = 1'b0;
    step();
    checks++;
    if (s_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_release: s_ready=%b want 1", s_ready);
    end
  endtask

  task automatic test_overlap();
    logic [7:0] pm;
    cfg(8'h1B, 4'd5, 1'b1, 16'd0);
    run_word(8'hDB, 0, 0, pm);
    step();
    checks++;
    if (pm !== 8'h90) begin
      errors++;
      $display("FAIL ovl_pulses: got %b want 10010000", pm);
    end
    checks++;
    if (match_cnt !== 16'd2) begin
      errors++;
      $display("FAIL ovl_cnt: got %0d want 2", match_cnt);
    end
  endtask

  task automatic test_nonoverlap();
    logic [7:0] pm;
    cfg(8'h1B, 4'd5, 1'b0, 16'd0);
    run_word(8'hDB, 0, 0, pm);
    step();
    checks++;
    if (pm !== 8'h10) begin
      errors++;
      $display("FAIL novl_pulses: got %b want 00010000", pm);
    end
    checks++;
    if (match_cnt !== 16'd1) begin
      errors++;
      $display("FAIL novl_cnt: got %0d want 1", match_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] pm;
    int   bcnt;
    logic r7, r15, i13, i14;
    cfg(8'h1B, 4'd5, 1'b1, 16'd3);
    pm = '0;
    r7 = 0; r15 = 0; i13 = 0; i14 = 0;
    s_valid = 1'b1;
    s_data  = 8'hDB;
    step();
    bcnt = busy ? 1 : 0;
    for (int k = 1; k <= 16; k++) begin
      step();
      if (k == 8) s_valid = 1'b0;
      if (k <= 15 && busy) bcnt++;
      pm[k-1] = det_pulse;
      if (k == 7)  r7  = s_ready;
      if (k == 15) r15 = s_ready;
      if (k == 13) i13 = irq;
      if (k == 14) i14 = irq;
    end
    checks++;
    if (r7 !== 1'b1 || r15 !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ready: last-bit ready=%b,%b want 1,1", r7, r15);
    end
    checks++;
    if (bcnt != 16 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_busy: cycles=%0d end=%b want 16 0", bcnt, busy);
    end
    checks++;
    if (pm !== 16'h9090) begin
      errors++;
      $display("FAIL b2b_pulses: got %h want 9090", pm);
    end
    checks++;
    if (i13 !== 1'b0 || i14 !== 1'b1) begin
      errors++;
      $display("FAIL b2b_irq_rise: %b->%b want 0->1", i13, i14);
    end
    step();
    checks++;
    if (match_cnt !== 16'd4 || irq !== 1'b1) begin
      errors++;
      $display("FAIL b2b_cnt: cnt=%0d irq=%b want 4 1", match_cnt, irq);
    end
    irq_clr = 1'b1;
    step();
    irq_clr = 1'b0;
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_clr: irq=%b want 0", irq);
    end
  endtask

  task automatic test_irq_clr_race();
    logic i5, i6;
    cfg(8'h1B, 4'd5, 1'b1, 16'd1);
    i5 = 1'b1;
    i6 = 1'b0;
    s_valid = 1'b1;
    s_data  = 8'hDB;
    step();
    s_valid = 1'b0;
    for (int j = 1; j <= 8; j++) begin
      if (j == 6) irq_clr = 1'b1;
      step();
      irq_clr = 1'b0;
      if (j == 5) i5 = irq;
      if (j == 6) i6 = irq;
    end
    checks++;
    if (i5 !== 1'b0 || i6 !== 1'b1) begin
      errors++;
      $display("FAIL irq_race: %b->%b want 0->1", i5, i6);
    end
    step();
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL irq_sticky: irq=%b want 1", irq);
    end
  endtask

  task automatic test_saturate();
    logic [7:0] pm0, pm1, pm2, pm3;
    cfg(8'hFF, 4'd8, 1'b1, 16'd0);
    run_word(8'hFF, 0, 0, pm0);
    run_word(8'hFF, 0, 0, pm1);
    run_word(8'hFF, 0, 0, pm2);
    step();
    checks++;
    if (pm0 !== 8'h80 || pm1 !== 8'hFF || pm2 !== 8'hFF) begin
      errors++;
      $display("FAIL ff_pulses: got %h %h %h want 80 ff ff", pm0, pm1, pm2);
    end
    checks++;
    if (match_cnt !== 16'd17) begin
      errors++;
      $display("FAIL ff_cnt: got %0d want 17", match_cnt);
    end
    checks++;
    if (match_cnt_s !== 4'd15) begin
      errors++;
      $display("FAIL sat_cnt: got %0d want 15", match_cnt_s);
    end
    run_word(8'hFF, 0, 0, pm3);
    step();
    checks++;
    if (match_cnt !== 16'd25 || match_cnt_s !== 4'd15) begin
      errors++;
      $display("FAIL sat_hold: cnt=%0d small=%0d want 25 15",
               match_cnt, match_cnt_s);
    end
  endtask

  task automatic test_reset_midword();
    logic [7:0] pm;
    cfg(8'h1B, 4'd5, 1'b1, 16'd0);
    s_valid = 1'b1;
    s_data  = 8'hDB;
    step();
    s_valid = 1'b0;
    for (int j = 1; j <= 4; j++) step();
    rst = 1'b1;
    step();
    checks++;
    if (s_ready !== 1'b0 || busy !== 1'b0 || det_pulse !== 1'b0 ||
        match_cnt !== 16'd0 || irq !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid: rdy=%b busy=%b det=%b cnt=%0d irq=%b want 0s",
               s_ready, busy, det_pulse, match_cnt, irq);
    end
    rst = 1'b0;
    step();
    checks++;
    if (det_pulse !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_drop: det=%b busy=%b want 0 0", det_pulse, busy);
    end
    cfg(8'h1B, 4'd5, 1'b1, 16'd0);
    run_word(8'hDB, 0, 0, pm);
    checks++;
    if (pm !== 8'h90) begin
      errors++;
      $display("FAIL rst_clean: got %b want 10010000", pm);
    end
  endtask

  task automatic test_cfg_in_shift();
    logic [7:0] pm;
    cfg(8'h1B, 4'd5, 1'b1, 16'd0);
    run_word(8'hDB, 2, 0, pm);
    step();
    checks++;
    if (pm !== 8'h90 || match_cnt !== 16'd2) begin
      errors++;
      $display("FAIL cfg_shift: pulses=%b cnt=%0d want 10010000 2",
               pm, match_cnt);
    end
  endtask

  task automatic test_enable_off();
    logic [7:0] pm;
    int         rdy;
    cfg(8'h1B, 4'd5, 1'b1, 16'd0);
    run_word(8'hDB, 0, 3, pm);
    checks++;
    if (pm !== 8'h90 || busy !== 1'b0) begin
      errors++;
      $display("FAIL en_finish: pulses=%b busy=%b want 10010000 0", pm, busy);
    end
    s_valid = 1'b1;
    rdy = 0;
    for (int j = 0; j < 4; j++) begin
      step();
      if (s_ready) rdy++;
    end
    checks++;
    if (rdy != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL en_hold: ready cycles=%0d busy=%b want 0 0", rdy, busy);
    end
    s_valid = 1'b0;
    enable  = 1'b1;
    step();
  endtask

  task automatic test_len_bounds();
    logic [7:0] pm;
    cfg(8'hFF, 4'd0, 1'b1, 16'd0);
    run_word(8'hFF, 0, 0, pm);
    step();
    checks++;
    if (pm !== 8'h00 || match_cnt !== 16'd0) begin
      errors++;
      $display("FAIL len0: pulses=%b cnt=%0d want 0 0", pm, match_cnt);
    end
    cfg(8'hFF, 4'd12, 1'b1, 16'd0);
    run_word(8'hFF, 0, 0, pm);
    checks++;
    if (pm !== 8'h80) begin
      errors++;
      $display("FAIL len_clamp: got %b want 10000000", pm);
    end
  endtask

  initial begin
    rst         = 1'b1;
    enable      = 1'b1;
    cfg_we      = 1'b0;
    cfg_pattern = '0;
    cfg_len     = '0;
    cfg_overlap = 1'b1;
    cfg_thresh  = '0;
    s_valid     = 1'b0;
    s_data      = '0;
    irq_clr     = 1'b0;
    test_reset();
    test_overlap();
    test_nonoverlap();
    test_back_to_back();
    test_irq_clr_race();
    test_saturate();
    test_reset_midword();
    test_cfg_in_shift();
    test_enable_off();
    test_len_bounds();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
